// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic command sequencer:
// sequencer FSM states, arithmetic unit op codes and status bit positions.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] OP_KONW  = 2'b00;
    localparam logic [1:0] OP_PORO  = 2'b01;
    localparam logic [1:0] OP_USTAW = 2'b10;
    localparam logic [1:0] OP_PRZES = 2'b11;

    localparam int ST_ERROR = 3;
    localparam int ST_NEZ   = 2;
    localparam int ST_ZEROS = 1;
    localparam int ST_OVF   = 0;

endpackage

// File: rtl/arith_cmd_sequencer_if.sv
// Bus bundle of the sequencer: command handshake, arithmetic unit operand /
// result ports and result handshake. The sequencer uses the slave view; the
// surrounding logic (command source, arithmetic unit, result sink) the master.
interface arith_cmd_sequencer_if #(
    parameter int BITS = 32
);
    // command channel
    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [BITS-1:0] i_cmd_A;
    logic [BITS-1:0] i_cmd_B;
    logic [1:0]      i_cmd_op;
    // arithmetic unit side
    logic [BITS-1:0] o_arg_A;
    logic [BITS-1:0] o_arg_B;
    logic [1:0]      o_op;
    logic [BITS-1:0] i_alu_result;
    logic [3:0]      i_alu_status;
    // result channel
    logic            o_res_valid;
    logic            i_res_ready;
    logic [BITS-1:0] o_result;
    logic [3:0]      o_status;

    modport slave (
        input  i_cmd_valid, i_cmd_A, i_cmd_B, i_cmd_op,
        input  i_alu_result, i_alu_status, i_res_ready,
        output o_cmd_ready, o_arg_A, o_arg_B, o_op,
        output o_res_valid, o_result, o_status
    );

    modport master (
        output i_cmd_valid, i_cmd_A, i_cmd_B, i_cmd_op,
        output i_alu_result, i_alu_status, i_res_ready,
        input  o_cmd_ready, o_arg_A, o_arg_B, o_op,
        input  o_res_valid, o_result, o_status
    );

endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries of {A, B, op}. Full/empty are registered flags,
// so a slot freed by a pop becomes usable on the following cycle, and a pushed
// entry is visible to the reader only after the push edge.
module cmd_fifo #(
    parameter int BITS  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [2*BITS+1:0]            wr_data,
    input  logic                         pop,
    output logic [2*BITS+1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int W     = 2*BITS+2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    // Storage write; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_next = level_reg;
        if (do_push && !do_pop) begin
            level_next = level_reg + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_next = level_reg - LVL_W'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
            full_reg  <= (level_next == LVL_W'(DEPTH));
            empty_reg <= (level_next == '0);
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;
    assign level   = level_reg;

endmodule

// File: rtl/arith_cmd_sequencer.sv
// Command front-end for the arithmetic unit: queues commands, issues one at a
// time (DRIVE), captures the unit's result at the end of DRIVE and holds it
// in RESP until the downstream handshake. Counts errored results, saturating.
module arith_cmd_sequencer
    import arith_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    arith_cmd_sequencer_if.slave         bus,
    output logic [CNT_W-1:0]             o_err_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_busy
);
    localparam int W = 2*BITS+2;

    state_t          state_reg;
    state_t          state_next;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [W-1:0]    fifo_wr_data;
    logic [W-1:0]    fifo_rd_data;
    logic [BITS-1:0] arg_a_reg;
    logic [BITS-1:0] arg_b_reg;
    logic [1:0]      op_reg;
    logic [BITS-1:0] result_reg;
    logic [3:0]      status_reg;
    logic            res_valid_reg;
    logic [CNT_W-1:0] err_count_reg;

    assign fifo_wr_data = {bus.i_cmd_A, bus.i_cmd_B, bus.i_cmd_op};

    cmd_fifo #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .push    (bus.i_cmd_valid),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_level)
    );

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pop request: pop when leaving IDLE or completing a RESP handshake.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.i_res_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = DRIVE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers: loaded from the FIFO head on each pop, stable otherwise.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            arg_a_reg <= '0;
            arg_b_reg <= '0;
            op_reg    <= '0;
        end else if (fifo_pop) begin
            {arg_a_reg, arg_b_reg, op_reg} <= fifo_rd_data;
        end
    end

    // Result capture at the end of DRIVE; valid drops on the downstream handshake.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            result_reg    <= '0;
            status_reg    <= '0;
            res_valid_reg <= 1'b0;
        end else if (state_reg == DRIVE) begin
            result_reg    <= bus.i_alu_result;
            status_reg    <= bus.i_alu_status;
            res_valid_reg <= 1'b1;
        end else if (state_reg == RESP && bus.i_res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    // Saturating count of captured results flagged as errors.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            err_count_reg <= '0;
        end else if (state_reg == DRIVE && bus.i_alu_status[ST_ERROR] &&
                     err_count_reg != {CNT_W{1'b1}}) begin
            err_count_reg <= err_count_reg + CNT_W'(1);
        end
    end

    assign bus.o_cmd_ready = !fifo_full;
    assign bus.o_arg_A     = arg_a_reg;
    assign bus.o_arg_B     = arg_b_reg;
    assign bus.o_op        = op_reg;
    assign bus.o_result    = result_reg;
    assign bus.o_status    = status_reg;
    assign bus.o_res_valid = res_valid_reg;
    assign o_err_count     = err_count_reg;
    assign o_busy          = (state_reg != IDLE);

endmodule
